// File: rtl/imem_boot_arbiter.sv
// imem_boot_arbiter: owns the single instruction-memory port.
// It first packs a byte-serial boot stream big-endian into 32-bit words and
// writes them from address 0 upward. Once the program is loaded it serves
// registered word fetches from the fetch stage.
module imem_boot_arbiter #(
  parameter  int MEM_BYTES = 512,
  localparam int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid_i,
  input  logic [7:0]    load_byte_i,
  input  logic          load_done_i,
  output logic          load_ready_o,
  input  logic          reload_i,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_ready_o,
  output logic          fetch_valid_o,
  output logic [31:0]   fetch_instr_o,
  output logic          boot_done_o,
  output logic [7:0]    word_count_o,
  output logic [AW-1:0] mem_A_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [1:0] {BOOT, WRITE, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic          last_q, last_d;
  logic          fvalid_q, fvalid_d;
  logic [31:0]   finstr_q, finstr_d;

  // shift register and byte count after taking this cycle's byte (if any)
  logic [31:0]   sh_nx;
  logic [1:0]    cnt_nx;

  // Move a partial word of cnt bytes (held in the low bytes) to the top,
  // zero-filling the low positions.
  function automatic logic [31:0] left_justify(input logic [31:0] sh,
                                               input logic [1:0]  cnt);
    case (cnt)
      2'd1:    left_justify = {sh[7:0],  24'h0};
      2'd2:    left_justify = {sh[15:0], 16'h0};
      2'd3:    left_justify = {sh[23:0], 8'h0};
      default: left_justify = sh;
    endcase
  endfunction

  // Next-state and output decode for the boot / write / run sequence.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    byte_cnt_d    = byte_cnt_q;
    shreg_d       = shreg_q;
    word_cnt_d    = word_cnt_q;
    last_d        = last_q;
    fvalid_d      = 1'b0;
    finstr_d      = finstr_q;
    sh_nx         = shreg_q;
    cnt_nx        = byte_cnt_q;
    load_ready_o  = 1'b0;
    mem_we_o      = 1'b0;
    mem_A_o       = wr_addr_q;
    fetch_ready_o = 1'b0;
    boot_done_o   = 1'b0;

    case (state_q)
      BOOT: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          sh_nx  = {shreg_q[23:0], load_byte_i};
          cnt_nx = byte_cnt_q + 2'd1;
        end
        shreg_d    = sh_nx;
        byte_cnt_d = cnt_nx;
        // A byte that completes the word wins over a pad; done then only
        // decides where to go after the write.
        if (load_valid_i && cnt_nx == 2'd0) begin
          state_d = WRITE;
          last_d  = load_done_i;
        end else if (load_done_i) begin
          if (cnt_nx == 2'd0) begin
            state_d = RUN;
          end else begin
            shreg_d = left_justify(sh_nx, cnt_nx);
            state_d = WRITE;
            last_d  = 1'b1;
          end
        end
      end

      WRITE: begin
        mem_we_o   = 1'b1;
        wr_addr_d  = wr_addr_q + AW'(4);
        word_cnt_d = word_cnt_q + 8'd1;
        shreg_d    = '0;
        byte_cnt_d = '0;
        last_d     = 1'b0;
        state_d    = (last_q || wr_addr_q == AW'(MEM_BYTES - 4)) ? RUN : BOOT;
      end

      RUN: begin
        boot_done_o   = 1'b1;
        fetch_ready_o = 1'b1;
        mem_A_o       = {fetch_addr_i[AW-1:2], 2'b00};
        if (reload_i) begin
          state_d    = BOOT;
          wr_addr_d  = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          shreg_d    = '0;
        end else if (fetch_req_i) begin
          fvalid_d = 1'b1;
          finstr_d = mem_rdata_i;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // State and datapath registers; reset clears everything including any
  // partial word and a pending fetch response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      wr_addr_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      word_cnt_q <= '0;
      last_q     <= 1'b0;
      fvalid_q   <= 1'b0;
      finstr_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      word_cnt_q <= word_cnt_d;
      last_q     <= last_d;
      fvalid_q   <= fvalid_d;
      finstr_q   <= finstr_d;
    end
  end

  assign mem_wdata_o   = shreg_q;
  assign word_count_o  = word_cnt_q;
  assign fetch_valid_o = fvalid_q;
  assign fetch_instr_o = finstr_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a behavioural 512-byte memory
// and a log of every write the block issues.
module tb_imem_boot_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid_i, load_done_i, reload_i, fetch_req_i;
  logic [7:0]  load_byte_i;
  logic [8:0]  fetch_addr_i;
  logic        load_ready_o, fetch_ready_o, fetch_valid_o, boot_done_o, mem_we_o;
  logic [31:0] fetch_instr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  word_count_o;
  logic [8:0]  mem_A_o;

  logic [31:0] mem [128];
  logic [8:0]  log_a [$];
  logic [31:0] log_d [$];
  logic [31:0] w13 [13];
  int          n_vec = 0;
  int          n_err = 0;

  imem_boot_arbiter #(.MEM_BYTES(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(load_valid_i), .load_byte_i(load_byte_i),
    .load_done_i(load_done_i), .load_ready_o(load_ready_o),
    .reload_i(reload_i), .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_ready_o(fetch_ready_o), .fetch_valid_o(fetch_valid_o),
    .fetch_instr_o(fetch_instr_o), .boot_done_o(boot_done_o),
    .word_count_o(word_count_o), .mem_A_o(mem_A_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_A_o[8:2]];

  always @(posedge clk) begin
    if (mem_we_o) begin
      mem[mem_A_o[8:2]] <= mem_wdata_o;
      log_a.push_back(mem_A_o);
      log_d.push_back(mem_wdata_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Offer one byte at a negedge once the block is ready, for one cycle.
  task automatic send_byte(input logic [7:0] b, input logic done);
    int t = 0;
    while (!load_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("load_ready_wait", 32'(load_ready_o), 32'd1);
    load_valid_i = 1'b1;
    load_byte_i  = b;
    load_done_i  = done;
    @(negedge clk);
    load_valid_i = 1'b0;
    load_done_i  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic done);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   done);
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  // Pulse reload (with a competing fetch request) while in RUN.
  task automatic do_reload();
    reload_i     = 1'b1;
    fetch_req_i  = 1'b1;
    fetch_addr_i = 9'h000;
    @(negedge clk);
    reload_i    = 1'b0;
    fetch_req_i = 1'b0;
    clear_log();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_load_ready"},  32'(load_ready_o),  32'd1);
    chk({tag, "_fetch_ready"}, 32'(fetch_ready_o), 32'd0);
    chk({tag, "_fetch_valid"}, 32'(fetch_valid_o), 32'd0);
    chk({tag, "_fetch_instr"}, fetch_instr_o,      32'd0);
    chk({tag, "_boot_done"},   32'(boot_done_o),   32'd0);
    chk({tag, "_word_count"},  32'(word_count_o),  32'd0);
    chk({tag, "_mem_we"},      32'(mem_we_o),      32'd0);
    chk({tag, "_mem_A"},       32'(mem_A_o),       32'd0);
    chk({tag, "_mem_wdata"},   mem_wdata_o,        32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid_i = 1'b0; load_done_i = 1'b0; load_byte_i = 8'h00;
    reload_i = 1'b0; fetch_req_i = 1'b0; fetch_addr_i = 9'h000;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, then done with no partial bytes.
    send_word(32'h2008_0005, 1'b0);
    chk("t1_we",    32'(mem_we_o), 32'd1);
    chk("t1_addr",  32'(mem_A_o),  32'd0);
    chk("t1_wdata", mem_wdata_o,   32'h2008_0005);
    chk("t1_ready_in_write", 32'(load_ready_o), 32'd0);
    @(negedge clk);
    chk("t1_wc",    32'(word_count_o), 32'd1);
    chk("t1_ready_after", 32'(load_ready_o), 32'd1);
    load_done_i = 1'b1;
    @(negedge clk);
    load_done_i = 1'b0;
    chk("t1_boot_done",   32'(boot_done_o),   32'd1);
    chk("t1_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("t1_nwrites",     32'(log_a.size()),  32'd1);
    fetch_req_i = 1'b1; fetch_addr_i = 9'h000;
    @(negedge clk);
    fetch_req_i = 1'b0;
    chk("t1_fvalid", 32'(fetch_valid_o), 32'd1);
    chk("t1_finstr", fetch_instr_o,      32'h2008_0005);
    @(negedge clk);
    chk("t1_fvalid_drop", 32'(fetch_valid_o), 32'd0);

    // Reload with a fetch in the same cycle; then 13 words, done on last byte.
    do_reload();
    chk("rl_fvalid",    32'(fetch_valid_o), 32'd0);
    chk("rl_boot_done", 32'(boot_done_o),   32'd0);
    chk("rl_wc",        32'(word_count_o),  32'd0);
    for (int i = 0; i < 13; i++) begin
      w13[i] = {8'(i), 8'hA5, 8'(3 * i), 8'h5A};
      send_word(w13[i], i == 12);
    end
    @(negedge clk);
    chk("t2_boot_done", 32'(boot_done_o),  32'd1);
    chk("t2_wc",        32'(word_count_o), 32'd13);
    @(negedge clk);
    chk("t2_nwrites",   32'(log_a.size()), 32'd13);
    chk("t2_first_addr", 32'(log_a[0]), 32'd0);
    chk("t2_last_addr",  32'(log_a[12]), 32'd48);
    for (int i = 0; i < 13; i++) begin
      fetch_req_i = 1'b1; fetch_addr_i = 9'(4 * i);
      @(negedge clk);
      chk($sformatf("t2_fv%0d", i), 32'(fetch_valid_o), 32'd1);
      chk($sformatf("t2_fi%0d", i), fetch_instr_o,      w13[i]);
    end
    fetch_addr_i = 9'h006;
    @(negedge clk);
    fetch_req_i = 1'b0;
    chk("t2_unaligned", fetch_instr_o, w13[1]);
    @(negedge clk);
    chk("t2_idle_fv",   32'(fetch_valid_o), 32'd0);
    chk("t2_idle_hold", fetch_instr_o,      w13[1]);

    // Full word then a 2-byte partial word padded on done.
    do_reload();
    send_word(32'h1122_3344, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    load_done_i = 1'b1;
    @(negedge clk);
    load_done_i = 1'b0;
    chk("t3_pad_we",    32'(mem_we_o), 32'd1);
    chk("t3_pad_addr",  32'(mem_A_o),  32'd4);
    chk("t3_pad_wdata", mem_wdata_o,   32'hAABB_0000);
    @(negedge clk);
    chk("t3_boot_done", 32'(boot_done_o),  32'd1);
    chk("t3_nwrites",   32'(log_a.size()), 32'd2);
    chk("t3_first",     log_d[0],          32'h1122_3344);

    // Fill the whole memory and try to push past the end.
    do_reload();
    for (int i = 0; i < 128; i++)
      send_word({8'(i), 8'(~i), 8'h3C, 8'(i + 1)}, 1'b0);
    @(negedge clk);
    chk("t4_boot_done", 32'(boot_done_o),   32'd1);
    chk("t4_ready",     32'(load_ready_o),  32'd0);
    chk("t4_wc",        32'(word_count_o),  32'd128);
    load_valid_i = 1'b1; load_byte_i = 8'h77;
    repeat (8) @(negedge clk);
    load_valid_i = 1'b0;
    chk("t4_nwrites",   32'(log_a.size()),  32'd128);
    chk("t4_last_addr", 32'(log_a[127]),    32'h1FC);
    chk("t4_last_data", log_d[127],         32'h7F80_3C80);
    chk("t4_ready_end", 32'(load_ready_o),  32'd0);
    chk("t4_wc_end",    32'(word_count_o),  32'd128);

    // Reset in the middle of a word, then a fresh word lands at address 0.
    do_reload();
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    send_word(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("t5_nwrites", 32'(log_a.size()), 32'd1);
    chk("t5_addr",    32'(log_a[0]),     32'd0);
    chk("t5_data",    log_d[0],          32'hDEAD_BEEF);
    chk("t5_wc",      32'(word_count_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_boot_arbiter.md
# imem_boot_arbiter

Owns the single port of the 512-byte instruction memory: first loads a program into it from a byte-serial boot source, then serves word fetches from the fetch stage. Bytes are packed big-endian, most-significant byte first, into 32-bit words at word-aligned byte addresses 0, 4, 8, …. The block sits between the boot/debug interface, the fetch stage and the memory's address/write/read pins.

## Interface
- MEM_BYTES, 512, memory size in bytes; address width 9; multiple of 4.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  boot byte present.
- load_byte  in  8  boot byte.
- load_done  in  1  end of program; level, sampled only while load_ready=1.
- load_ready  out  1  block accepts a byte this cycle.
- reload  in  1  single-cycle pulse; re-enter boot from RUN.
- fetch_req  in  1  fetch request.
- fetch_addr  in  9  fetch byte address; bits [1:0] ignored.
- fetch_ready  out  1  fetch port available.
- fetch_valid  out  1  fetch_instr valid; 1-cycle pulse per accepted request.
- fetch_instr  out  32  fetched word, registered.
- boot_done  out  1  program loaded; fetch port live.
- word_count  out  8  words written since last boot start.
- mem_A  out  9  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational from mem_A.

## Operation
- States: BOOT, WRITE, RUN. Reset → BOOT with wr_addr=0, byte_cnt=0, shift register=0.
- BOOT: load_ready=1. On load_valid, shift the byte into the low byte of the 32-bit shift register, then increment byte_cnt (mod 4). The 4th byte → WRITE.
- WRITE (exactly 1 cycle):
  - load_ready=0; mem_we=1, mem_A=wr_addr, mem_wdata=shift register.
  - Then: wr_addr+=4, word_count+=1, shift register and byte_cnt cleared.
  - Next state is BOOT, or RUN if this was the pad write or wr_addr was MEM_BYTES-4.
- load_done seen in BOOT:
  - byte_cnt=0 → RUN.
  - byte_cnt≠0 → pad the partial word with zero bytes in the low positions (left-justified) → WRITE → RUN.
  - load_done together with load_valid: the byte is accepted first, then done is processed on the updated byte_cnt. If that byte completes the word, no pad write occurs: WRITE → RUN.
- Memory full: after the write to address MEM_BYTES-4, go to RUN. load_ready stays 0; further bytes are never accepted.
- RUN:
  - boot_done=1, fetch_ready=1, mem_we=0, mem_A={fetch_addr[8:2],2'b00}.
  - On fetch_req, register mem_rdata into fetch_instr and assert fetch_valid in the next cycle.
  - Back-to-back requests are serviced every cycle. Without fetch_req, fetch_valid=0 and fetch_instr holds.
- reload in RUN → BOOT next cycle:
  - wr_addr, word_count, byte_cnt cleared; boot_done=0; fetch_valid forced 0.
  - A fetch_req in the same cycle is dropped.
  - reload outside RUN is ignored.
- mem_A outside RUN = wr_addr. mem_wdata = shift register at all times.
- fetch_req outside RUN is ignored; no fetch_valid is produced.

## Timing
- Reset values: load_ready=1, fetch_ready=0, fetch_valid=0, fetch_instr=0, boot_done=0, word_count=0, mem_we=0, mem_A=0, mem_wdata=0.
- Reset asserted mid-boot or mid-fetch clears all state immediately, including any in-flight word and a pending fetch_valid.
- Byte-to-write latency: 4th byte accepted at edge N → mem_we high during cycle N+1 → load_ready high again from N+2.
- Throughput: 4 bytes per 5 cycles.
- Fetch latency: request cycle N → fetch_valid/fetch_instr during cycle N+1.
- boot_done and fetch_ready rise in the first cycle of RUN.
- word_count saturates naturally at MEM_BYTES/4 = 128.

## Test plan
- Reset, then bytes 0x20,0x08,0x00,0x05 and load_done → one write: mem_A=0, mem_wdata=0x20080005, word_count=1. Then boot_done=1 and fetch of address 0 → fetch_instr=0x20080005 one cycle later.
- Load 13 words, then fetch A=0,4,…,48 back-to-back → each word returned in order, one per cycle. fetch_addr=0x006 → word at 0x004.
- Partial word 0xAA,0xBB then load_done → pad write 0xAABB0000 at the next aligned address, then RUN.
  - Variant: load_done together with the 4th byte → exactly one write, no pad write.
- Stream 130 words → 128 writes; the last write is to 0x1FC; RUN is entered; load_ready=0 thereafter; word_count=128.
- reload in RUN with fetch_req high → no fetch_valid; BOOT entered; the next program overwrites from address 0.
- rst_n pulsed low after 2 bytes of a word → all outputs at reset values. The next 4 bytes form a fresh word written at address 0.
